// File: rtl/mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// mdu_issue_ctrl
//   EX-stage sequencer that feeds multi_cycle. One multiply-accumulate or
//   divide instruction is accepted from the EX pipeline register. Its
//   operands are latched and held stable on the mc_* outputs until
//   multi_cycle reports done. The 64-bit {HI,LO} result is then registered
//   and announced with a one-cycle write-back strobe.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   exception_flush   cancels any operation, highest priority
//   issue_valid       EX holds a valid instruction
//   issue_inst        decoded instruction code
//   issue_op1/op2     rs / rt operands
//   issue_hilo        current {HI,LO}, already forwarded
//   mc_inst           instruction to multi_cycle (NOP when not busy)
//   mc_op1/op2/hilo   latched operands to multi_cycle
//   mc_result         multi_cycle result {hi,lo}
//   mc_done           multi_cycle completion
//   stall_req         holds IF/ID/EX
//   wb_valid          one-cycle HI/LO write strobe
//   wb_hilo           value to write into HI/LO
//   mdu_timeout       one-cycle pulse when the watchdog aborts an operation
// ---------------------------------------------------------------------------
module mdu_issue_ctrl #(
  parameter int unsigned MAX_BUSY_CYCLES = 64,  // must exceed DIV_CYCLES+1
  parameter int unsigned CNT_WIDTH       = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exception_flush,
  input  logic        issue_valid,
  input  logic [7:0]  issue_inst,
  input  logic [31:0] issue_op1,
  input  logic [31:0] issue_op2,
  input  logic [63:0] issue_hilo,
  output logic [7:0]  mc_inst,
  output logic [31:0] mc_op1,
  output logic [31:0] mc_op2,
  output logic [63:0] mc_hilo,
  input  logic [63:0] mc_result,
  input  logic        mc_done,
  output logic        stall_req,
  output logic        wb_valid,
  output logic [63:0] wb_hilo,
  output logic        mdu_timeout
);

  // Instruction codes shared with the decoder.
  localparam logic [7:0] INST_NOP   = 8'h00;
  localparam logic [7:0] INST_DIV   = 8'h1A;
  localparam logic [7:0] INST_DIVU  = 8'h1B;
  localparam logic [7:0] INST_MADD  = 8'hA6;
  localparam logic [7:0] INST_MADDU = 8'hA8;
  localparam logic [7:0] INST_MSUB  = 8'hAA;
  localparam logic [7:0] INST_MSUBU = 8'hAB;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_BUSY_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]           inst_q;
  logic [31:0]          op1_q;
  logic [31:0]          op2_q;
  logic [63:0]          hilo_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [63:0]          wb_hilo_q;
  logic                 timeout_q;

  logic is_mc;
  logic accept;
  logic busy_last;

  always_comb begin
    is_mc = issue_inst inside {INST_DIV, INST_DIVU, INST_MADD,
                               INST_MADDU, INST_MSUB, INST_MSUBU};
  end

  assign accept    = (state_q == IDLE) && issue_valid && is_mc && !exception_flush;
  // Watchdog terminal count; mc_done in the same cycle takes precedence.
  assign busy_last = (state_q == BUSY) && !mc_done && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (exception_flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = BUSY;
        BUSY: begin
          if (mc_done) begin
            state_d = DONE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic. NOP outside BUSY keeps multi_cycle's divide counter from
  // restarting once it has reported done.
  always_comb begin
    stall_req = 1'b0;
    wb_valid  = 1'b0;
    mc_inst   = INST_NOP;
    if (!exception_flush) begin
      case (state_q)
        IDLE: stall_req = accept;
        BUSY: begin
          stall_req = 1'b1;
          mc_inst   = inst_q;
        end
        DONE:    wb_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand latches, watchdog counter, result register, timeout pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= INST_NOP;
      op1_q     <= '0;
      op2_q     <= '0;
      hilo_q    <= '0;
      cnt_q     <= '0;
      wb_hilo_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        inst_q <= issue_inst;
        op1_q  <= issue_op1;
        op2_q  <= issue_op2;
        hilo_q <= issue_hilo;
      end

      if (exception_flush || accept) begin
        cnt_q <= '0;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end

      if (!exception_flush && (state_q == BUSY) && mc_done) begin
        wb_hilo_q <= mc_result;
      end

      timeout_q <= !exception_flush && busy_last;
    end
  end

  assign mc_op1      = op1_q;
  assign mc_op2      = op2_q;
  assign mc_hilo     = hilo_q;
  assign wb_hilo     = wb_hilo_q;
  assign mdu_timeout = timeout_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for mdu_issue_ctrl. A stub multi_cycle answers MADD-family ops
// combinationally and divides after 37 busy cycles; a transaction-level model
// predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_mdu_issue_ctrl;

  localparam int MAXB    = 64;
  localparam int DIV_LAT = 37;

  localparam logic [7:0] I_DIV   = 8'h1A;
  localparam logic [7:0] I_DIVU  = 8'h1B;
  localparam logic [7:0] I_MADD  = 8'hA6;
  localparam logic [7:0] I_MADDU = 8'hA8;
  localparam logic [7:0] I_MSUB  = 8'hAA;
  localparam logic [7:0] I_MSUBU = 8'hAB;
  localparam logic [7:0] I_ADDU  = 8'h21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exception_flush;
  logic        issue_valid;
  logic [7:0]  issue_inst;
  logic [31:0] issue_op1;
  logic [31:0] issue_op2;
  logic [63:0] issue_hilo;
  logic [7:0]  mc_inst;
  logic [31:0] mc_op1;
  logic [31:0] mc_op2;
  logic [63:0] mc_hilo;
  logic [63:0] mc_result;
  logic        mc_done;
  logic        stall_req;
  logic        wb_valid;
  logic [63:0] wb_hilo;
  logic        mdu_timeout;

  logic hang = 1'b0;
  logic spur = 1'b0;
  int   stub_cnt;

  int n_checks = 0;
  int n_errors = 0;

  mdu_issue_ctrl #(
    .MAX_BUSY_CYCLES(64),
    .CNT_WIDTH(7)
  ) dut (
    .clk(clk), .rst_n(rst_n), .exception_flush(exception_flush),
    .issue_valid(issue_valid), .issue_inst(issue_inst),
    .issue_op1(issue_op1), .issue_op2(issue_op2), .issue_hilo(issue_hilo),
    .mc_inst(mc_inst), .mc_op1(mc_op1), .mc_op2(mc_op2), .mc_hilo(mc_hilo),
    .mc_result(mc_result), .mc_done(mc_done), .stall_req(stall_req),
    .wb_valid(wb_valid), .wb_hilo(wb_hilo), .mdu_timeout(mdu_timeout)
  );

  always #5 clk = ~clk;

  function automatic bit is_mc(input logic [7:0] i);
    return (i == I_DIV) || (i == I_DIVU) || (i == I_MADD) || (i == I_MADDU) ||
           (i == I_MSUB) || (i == I_MSUBU);
  endfunction

  function automatic bit is_div(input logic [7:0] i);
    return (i == I_DIV) || (i == I_DIVU);
  endfunction

  // Architectural result of an MDU instruction.
  function automatic logic [63:0] calc(input logic [7:0] i, input logic [31:0] a,
                                       input logic [31:0] b, input logic [63:0] h);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub;
    logic signed [31:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (i)
      I_MADD:  return h + 64'(sa * sb);
      I_MADDU: return h + ua * ub;
      I_MSUB:  return h - 64'(sa * sb);
      I_MSUBU: return h - ua * ub;
      I_DIV: begin
        if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return '0;
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      I_DIVU: begin
        if (b == 32'd0) return '0;
        return {a % b, a / b};
      end
      default: return '0;
    endcase
  endfunction

  // Stub multi_cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) stub_cnt <= 0;
    else        stub_cnt <= is_div(mc_inst) ? stub_cnt + 1 : 0;
  end

  always_comb begin
    mc_result = calc(mc_inst, mc_op1, mc_op2, mc_hilo);
    if (mc_inst == 8'h00)     mc_done = spur;
    else if (hang)            mc_done = 1'b0;
    else if (is_div(mc_inst)) mc_done = (stub_cnt == DIV_LAT - 1);
    else                      mc_done = 1'b1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an op in flight with its age, a pending retire, a
  // pending timeout pulse.
  bit          m_busy = 0;
  bit          m_wb = 0;
  bit          m_to = 0;
  bit          m_hang = 0;
  int          m_age = 0;
  logic [7:0]  m_inst = '0;
  logic [31:0] m_op1 = '0;
  logic [31:0] m_op2 = '0;
  logic [63:0] m_hilo = '0;
  logic [63:0] m_wb_hilo = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_wb = 0; m_to = 0; m_age = 0;
      m_inst = '0; m_op1 = '0; m_op2 = '0; m_hilo = '0; m_wb_hilo = '0;
    end else begin
      bit fin;
      fin  = !m_hang && (is_div(m_inst) ? (m_age == DIV_LAT - 1) : 1'b1);
      m_to = 0;
      if (exception_flush) begin
        m_busy = 0;
        m_wb   = 0;
      end else if (m_busy) begin
        if (fin) begin
          m_busy    = 0;
          m_wb      = 1;
          m_wb_hilo = calc(m_inst, m_op1, m_op2, m_hilo);
        end else if (m_age == MAXB - 1) begin
          m_busy = 0;
          m_to   = 1;
        end else begin
          m_age++;
        end
      end else if (m_wb) begin
        m_wb = 0;
      end else if (issue_valid && is_mc(issue_inst)) begin
        m_busy = 1; m_age = 0; m_hang = hang;
        m_inst = issue_inst; m_op1 = issue_op1; m_op2 = issue_op2; m_hilo = issue_hilo;
      end
    end
  end

  // Compare process
  always @(negedge clk) begin
    bit acc;
    acc = !m_busy && !m_wb && issue_valid && is_mc(issue_inst) && !exception_flush;
    chk("stall_req", {63'b0, stall_req}, {63'b0, !exception_flush && (m_busy || acc)});
    chk("wb_valid", {63'b0, wb_valid}, {63'b0, m_wb && !exception_flush});
    chk("mc_inst", {56'b0, mc_inst}, {56'b0, (m_busy && !exception_flush) ? m_inst : 8'h00});
    chk("mdu_timeout", {63'b0, mdu_timeout}, {63'b0, m_to});
    chk("wb_hilo", wb_hilo, m_wb_hilo);
    if (m_busy) begin
      chk("mc_op1", {32'b0, mc_op1}, {32'b0, m_op1});
      chk("mc_op2", {32'b0, mc_op2}, {32'b0, m_op2});
      chk("mc_hilo", mc_hilo, m_hilo);
    end
  end

  task automatic run_op(input string nm, input logic [7:0] inst, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] h,
                        input int exp_stalls, input logic [63:0] exp_res);
    int stalls;
    bit got;
    stalls = 0;
    got    = 0;
    @(posedge clk); #2;
    issue_valid = 1'b1; issue_inst = inst; issue_op1 = a; issue_op2 = b; issue_hilo = h;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk); #1;
      if (wb_valid) begin
        got = 1;
        chk({nm, "_stalls"}, 64'(stalls), 64'(exp_stalls));
        chk({nm, "_wb_hilo"}, wb_hilo, exp_res);
        chk({nm, "_mc_inst_done"}, {56'b0, mc_inst}, 64'h0);
      end else if (stall_req) begin
        stalls++;
      end
    end
    if (!got) chk({nm, "_wb_seen"}, 64'd0, 64'd1);
    @(posedge clk); #2;
    issue_valid = 1'b0; issue_inst = 8'h00;
    @(negedge clk); #1;
    chk({nm, "_mc_inst_idle"}, {56'b0, mc_inst}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int stalls, to_cnt, wbs, stalls_at_to;
    bit held;
    logic [7:0]  ri;
    logic [31:0] ra, rb;

    rst_n = 1'b0; exception_flush = 1'b0; issue_valid = 1'b0;
    issue_inst = '0; issue_op1 = '0; issue_op2 = '0; issue_hilo = '0;

    @(negedge clk); #1;
    chk("rst_mc_inst", {56'b0, mc_inst}, 64'h0);
    chk("rst_stall", {63'b0, stall_req}, 64'h0);
    chk("rst_wb_hilo", wb_hilo, 64'h0);
    chk("rst_mc_op1", {32'b0, mc_op1}, 64'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    run_op("maddu", I_MADDU, 32'h3, 32'h5, 64'h10, 2, 64'h1F);
    run_op("div", I_DIV, 32'hFFFF_FFF9, 32'h2, 64'h0, 38, 64'hFFFF_FFFF_FFFF_FFFD);

    // Non-MC instruction with valid, then MC instruction without valid
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #2;
      issue_valid = (k < 3); issue_inst = (k < 3) ? I_ADDU : I_DIV;
      @(negedge clk); #1;
      chk("nonmc_stall", {63'b0, stall_req}, 64'h0);
      chk("nonmc_mc_inst", {56'b0, mc_inst}, 64'h0);
    end

    // Flush in BUSY cycle 10
    @(posedge clk); #2;
    issue_valid = 1'b1; issue_inst = I_DIV; issue_op1 = 32'd1000; issue_op2 = 32'd3;
    repeat (10) @(posedge clk);
    #2 exception_flush = 1'b1;
    @(negedge clk); #1;
    chk("flush_stall", {63'b0, stall_req}, 64'h0);
    chk("flush_mc_inst", {56'b0, mc_inst}, 64'h0);
    @(posedge clk); #2;
    exception_flush = 1'b0; issue_valid = 1'b0; issue_inst = 8'h00;
    wbs = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk); #1;
      if (wb_valid) wbs++;
    end
    chk("flush_no_wb", 64'(wbs), 64'd0);
    run_op("divu", I_DIVU, 32'd100, 32'd7, 64'h0, 38, {32'd2, 32'd14});

    // Watchdog: multi_cycle never answers
    hang = 1'b1;
    stalls = 0; to_cnt = 0; wbs = 0; stalls_at_to = -1;
    @(posedge clk); #2;
    issue_valid = 1'b1; issue_inst = I_DIV; issue_op1 = 32'd9; issue_op2 = 32'd4;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (stall_req) stalls++;
      if (wb_valid) wbs++;
      if (mdu_timeout) begin
        to_cnt++;
        if (stalls_at_to < 0) stalls_at_to = stalls;
      end
      if (c == 0) begin
        @(posedge clk); #2;
        issue_valid = 1'b0; issue_inst = 8'h00;
      end
    end
    chk("wd_stalls", 64'(stalls_at_to), 64'd65);
    chk("wd_pulses", 64'(to_cnt), 64'd1);
    chk("wd_no_wb", 64'(wbs), 64'd0);
    hang = 1'b0;

    // Randomised traffic; an instruction stays in EX while stalled
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      exception_flush = ($urandom_range(0, 49) == 0);
      spur = 1'($urandom_range(0, 1));
      if (!held) begin
        case ($urandom_range(0, 8))
          0: ri = I_DIV;
          1: ri = I_DIVU;
          2: ri = I_MADD;
          3: ri = I_MADDU;
          4: ri = I_MSUB;
          5: ri = I_MSUBU;
          6: ri = I_ADDU;
          7: ri = 8'h00;
          default: ri = 8'($urandom);
        endcase
        ra = $urandom;
        rb = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
        if (rb == 32'd0) rb = 32'd1;
        if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
        issue_valid = ($urandom_range(0, 3) != 0);
        issue_inst = ri; issue_op1 = ra; issue_op2 = rb;
        issue_hilo = {$urandom, $urandom};
      end
      @(negedge clk); #1;
      held = stall_req;
    end
    @(posedge clk); #2;
    exception_flush = 1'b0; issue_valid = 1'b0; issue_inst = 8'h00; spur = 1'b0;
    repeat (45) @(posedge clk);

    // Asynchronous reset in the middle of a divide
    #2;
    issue_valid = 1'b1; issue_inst = I_DIV; issue_op1 = 32'd77; issue_op2 = 32'd5;
    issue_hilo = 64'h1234;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    issue_valid = 1'b0; issue_inst = 8'h00;
    #1;
    chk("arst_mc_inst", {56'b0, mc_inst}, 64'h0);
    chk("arst_mc_op1", {32'b0, mc_op1}, 64'h0);
    chk("arst_mc_op2", {32'b0, mc_op2}, 64'h0);
    chk("arst_mc_hilo", mc_hilo, 64'h0);
    chk("arst_stall", {63'b0, stall_req}, 64'h0);
    chk("arst_wb_valid", {63'b0, wb_valid}, 64'h0);
    chk("arst_wb_hilo", wb_hilo, 64'h0);
    chk("arst_timeout", {63'b0, mdu_timeout}, 64'h0);
    @(posedge clk); #2 rst_n = 1'b1;

    run_op("msub", I_MSUB, 32'd2, 32'd3, 64'h100, 2, 64'hFA);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
